// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: walks the register file from index 0 to NREGS-1. Each
// register is captured as a 32-bit word and sent to the debug transmitter
// one byte at a time, least significant byte first, with valid/ready
// handshaking. o_busy asks the pipeline to stall while a dump is running.
// o_done pulses for one cycle when the last byte has been accepted.
module reg_dump_ctrl #(
  parameter int NREGS = 32,
  parameter int BPW   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [4:0]  o_rd_sel,
  input  logic [31:0] i_rd_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done
);

  localparam int BCW = (BPW > 32'd1) ? $clog2(BPW) : 1;
  localparam logic [4:0]     LAST_IDX  = 5'(NREGS - 32'd1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 32'd1);
  localparam logic [BCW-1:0] BYTE_ONE  = BCW'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         state_r;
  logic [4:0]     index_r;
  logic [BCW-1:0] byte_cnt_r;
  logic [31:0]    word_r;
  logic [7:0]     tx_data_r;
  logic           tx_valid_r;
  logic           busy_r;
  logic           done_r;

  // Select byte n of a word, byte 0 being the least significant.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [BCW-1:0] n);
    logic [31:0] sh;
    sh = w >> {n, 3'b000};
    return sh[7:0];
  endfunction

  // The read select is the index register itself, so it is registered by construction.
  assign o_rd_sel   = index_r;
  assign o_tx_data  = tx_data_r;
  assign o_tx_valid = tx_valid_r;
  assign o_busy     = busy_r;
  assign o_done     = done_r;

  // Dump sequencer: state, counters, snapshot word and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r    <= ST_IDLE;
      index_r    <= 5'd0;
      byte_cnt_r <= '0;
      word_r     <= 32'd0;
      tx_data_r  <= 8'd0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_valid_r <= 1'b0;
          done_r     <= 1'b0;
          if (i_start) begin
            index_r <= 5'd0;
            busy_r  <= 1'b1;
            state_r <= ST_LOAD;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          // Snapshot the word so later register-file changes cannot leak into the stream.
          word_r     <= i_rd_data;
          byte_cnt_r <= '0;
          tx_data_r  <= i_rd_data[7:0];
          tx_valid_r <= 1'b1;
          state_r    <= ST_SEND;
        end
        ST_SEND: begin
          if (i_tx_ready) begin
            if (byte_cnt_r != LAST_BYTE) begin
              byte_cnt_r <= byte_cnt_r + BYTE_ONE;
              tx_data_r  <= byte_of(word_r, byte_cnt_r + BYTE_ONE);
              state_r    <= ST_SEND;
            end else begin
              tx_valid_r <= 1'b0;
              if (index_r == LAST_IDX) begin
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                index_r <= index_r + 5'd1;
                state_r <= ST_LOAD;
              end
            end
          end else begin
            // Transmitter stalled: data, byte count and index all hold.
            state_r <= ST_SEND;
          end
        end
        ST_DONE: begin
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          tx_valid_r <= 1'b0;
          index_r    <= 5'd0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          index_r    <= 5'd0;
          byte_cnt_r <= '0;
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of registers dumped (indices 0..NREGS-1).
REQ-002 SHALL have parameter BPW, default 4, bytes per 32-bit word.
REQ-003 SHALL have port i_clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port i_start  in  1  dump request, sampled only in IDLE.
REQ-006 SHALL have port o_rd_sel  out  5  register-file read select.
REQ-007 SHALL have port i_rd_data  in  32  register-file read data, combinational from o_rd_sel.
REQ-008 SHALL have port o_tx_data  out  8  byte to debug transmitter.
REQ-009 SHALL have port o_tx_valid  out  1  o_tx_data valid.
REQ-010 SHALL have port i_tx_ready  in  1  transmitter accepts byte.
REQ-011 SHALL have port o_busy  out  1  dump in progress; pipeline stall request.
REQ-012 SHALL have port o_done  out  1  one-cycle pulse at dump end.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SEND, DONE; registered outputs only.
REQ-014 IDLE: o_busy=0, o_tx_valid=0; on i_start=1 set reg index=0 and go to LOAD; else stay.
REQ-015 LOAD (one cycle): o_rd_sel=index; capture i_rd_data into 32-bit word register; byte_cnt=0; go to SEND.
REQ-016 SEND: o_tx_valid=1; o_tx_data=word[8*byte_cnt+7 : 8*byte_cnt], LSB byte first.
REQ-017 Transfer occurs only on a cycle with o_tx_valid=1 and i_tx_ready=1; exactly one byte per transfer.
REQ-018 While o_tx_valid=1 and i_tx_ready=0, o_tx_data, byte_cnt, index SHALL hold unchanged.
REQ-019 On transfer with byte_cnt<BPW-1: byte_cnt+1, stay SEND.
REQ-020 On transfer with byte_cnt=BPW-1: if index=NREGS-1 go to DONE, else index+1 and go to LOAD.
REQ-021 DONE (one cycle): o_done=1, o_busy=1, o_tx_valid=0; then IDLE with index=0.
REQ-022 o_busy=1 in LOAD, SEND, DONE; asserted from the cycle after i_start is sampled.
REQ-023 o_rd_sel SHALL always equal index; index width 5 bits, never exceeds NREGS-1, no wrap.
REQ-024 i_start asserted outside IDLE SHALL be ignored (no restart, no queued request).
REQ-025 Latency, i_tx_ready held 1, i_start sampled at edge k: LOAD in cycle k+1; register r LOAD at k+1+5r; first o_tx_valid at k+2; o_done high in cycle k+161; IDLE at k+162.
REQ-026 Total output per dump: NREGS*BPW = 128 bytes, register order 0..31.
REQ-027 Register 0 SHALL be dumped as whatever i_rd_data returns (0x00000000 from register file).
REQ-028 Word is snapshot at LOAD; changes on i_rd_data during SEND SHALL NOT affect bytes sent.

Reset
REQ-029 On rising edge with i_rst=0: state=IDLE, index=0, byte_cnt=0, word=0, o_rd_sel=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
REQ-030 Reset mid-dump SHALL abort immediately with no further bytes; partial stream is not resumed.
REQ-031 i_start is ignored while i_rst=0.

Verification
REQ-032 Regfile model reg[i]={8'hA5,16'h0,i[7:0]}, reg[0]=0, ready=1, start pulse at edge k -> 128 bytes; bytes 4..7 = 01,00,00,A5; last 4 = 1F,00,00,A5; o_done only in cycle k+161.
REQ-033 Hold i_tx_ready=0 for 3 cycles during byte 2 of reg 5 -> o_tx_valid=1, o_tx_data=0x00 stable all 3 cycles; stream unchanged after release.
REQ-034 Pulse i_start again at cycle k+40 -> ignored; exactly 128 bytes, single o_done.
REQ-035 Drive i_rst=0 after byte 50 accepted -> next cycle o_tx_valid=0, o_busy=0, o_rd_sel=0; new start restarts from reg 0 byte 0.
REQ-036 Toggle i_tx_ready every cycle -> byte stream identical to REQ-032; o_done delayed accordingly.
REQ-037 Change regfile model value of current register during its SEND -> sent bytes equal the LOAD-time snapshot.
